// File: rtl/spi_slave_mlf.sv
// SPI slave endpoint: oversampled SCK/CS_n/MOSI, MSB-first byte shifter, one-deep TX holding buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release MISO (1'bz) while idle or in reset.
module spi_slave_mlf #(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_SPI_clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO
);

  localparam logic [1:0] MODE = 2'(SPI_MODE);
  localparam logic       CPOL = MODE[1];
  localparam logic       CPHA = MODE[0];

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ACTIVE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sck_s, cs_s, mosi_s;
  logic       sck_d, cs_d;
  logic       sck_rise, sck_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, cs_fall, cs_hi;
  logic       load, sample_en, shift_en, byte_done, reload, abort, tx_accept;
  logic [7:0] shift_tx, rx_shift, hold, next_byte;
  logic       hold_full;
  logic [2:0] bit_cnt;
  logic       miso_q, rx_dv_q;

  // CS_n chain resets low so a select already asserted across reset never looks like a fresh falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_s  <= {2{CPOL}};
      sck_d  <= CPOL;
      cs_s   <= 2'b00;
      cs_d   <= 1'b0;
      mosi_s <= 2'b00;
    end else begin
      sck_s  <= {sck_s[0], i_SPI_clk};
      sck_d  <= sck_s[1];
      cs_s   <= {cs_s[0], i_SPI_CS_n};
      cs_d   <= cs_s[1];
      mosi_s <= {mosi_s[0], i_SPI_MOSI};
    end
  end

  assign sck_rise    = sck_s[1] & ~sck_d;
  assign sck_fall    = ~sck_s[1] & sck_d;
  assign lead_edge   = CPOL ? sck_fall : sck_rise;
  assign trail_edge  = CPOL ? sck_rise : sck_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_d & ~cs_s[1];
  assign cs_hi       = cs_s[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cs_hi) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign byte_done = sample_en & (bit_cnt == 3'd7);
  assign reload    = load | byte_done;
  assign next_byte = hold_full ? hold : IDLE_BYTE;
  assign tx_accept = i_TX_DV & ~hold_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_tx  <= IDLE_BYTE;
      rx_shift  <= 8'h00;
      bit_cnt   <= 3'd0;
      miso_q    <= 1'b1;
      o_RX_Byte <= 8'h00;
      rx_dv_q   <= 1'b0;
    end else begin
      rx_dv_q <= byte_done;
      if (abort) miso_q <= 1'b1;
      if (sample_en) begin
        rx_shift <= {rx_shift[6:0], mosi_s[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) o_RX_Byte <= {rx_shift[6:0], mosi_s[1]};
      end
      // With CPHA=0 the trailing edge right after a reload must not push out the fresh MSB.
      if (shift_en && (CPHA || bit_cnt != 3'd0)) begin
        miso_q   <= shift_tx[7];
        shift_tx <= {shift_tx[6:0], 1'b1};
      end
      if (reload) begin
        bit_cnt <= 3'd0;
        if (CPHA) begin
          shift_tx <= next_byte;
        end else begin
          miso_q   <= next_byte[7];
          shift_tx <= {next_byte[6:0], 1'b1};
        end
      end
    end
  end

  // A write landing in the same cycle as a reload from an empty buffer is kept for the following byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_full <= 1'b0;
      hold      <= 8'h00;
    end else begin
      if (reload) hold_full <= 1'b0;
      if (tx_accept) begin
        hold_full <= 1'b1;
        hold      <= i_TX_Byte;
      end
    end
  end

  assign o_TX_Ready = ~hold_full;
  assign o_RX_DV    = rx_dv_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign o_SPI_MISO = (i_rst || state_q == ST_IDLE) ? 1'bz : miso_q;
`else
  assign o_SPI_MISO = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_mlf.sv
// Bench for spi_slave_mlf: one instance per SPI mode, a bit-banged master and a buffer/byte-level model.
`timescale 1ns/1ps
module tb_spi_slave_mlf;

  localparam int HALF = 5;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b1;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       sck      [4];
  logic       cs_n     [4];
  logic       mosi     [4];
  logic       tx_dv    [4];
  logic [7:0] tx_byte  [4];
  logic       tx_ready [4];
  logic       rx_dv    [4];
  logic [7:0] rx_byte  [4];
  logic       miso     [4];

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_mlf #(.SPI_MODE(g), .IDLE_BYTE(8'hFF)) u_dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_TX_Byte  (tx_byte[g]),
      .i_TX_DV    (tx_dv[g]),
      .o_TX_Ready (tx_ready[g]),
      .o_RX_DV    (rx_dv[g]),
      .o_RX_Byte  (rx_byte[g]),
      .i_SPI_clk  (sck[g]),
      .i_SPI_CS_n (cs_n[g]),
      .i_SPI_MOSI (mosi[g]),
      .o_SPI_MISO (miso[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RX log filled from the DUT pulses; one entry per o_RX_DV cycle
  logic [7:0] rx_log [4][64];
  int         rx_cnt [4];
  initial for (int i = 0; i < 4; i++) rx_cnt[i] = 0;
  always @(negedge i_clk)
    for (int i = 0; i < 4; i++)
      if (rx_dv[i] === 1'b1) begin
        rx_log[i][rx_cnt[i] % 64] = rx_byte[i];
        rx_cnt[i] = rx_cnt[i] + 1;
      end

  // Reference model: holding buffer per mode and the last complete byte per mode
  bit         hb_full_m [4];
  logic [7:0] hb_m      [4];
  logic [7:0] exp_last  [4];

  function automatic logic [7:0] model_start(input int m);
    logic [7:0] r;
    r = hb_full_m[m] ? hb_m[m] : 8'hFF;
    hb_full_m[m] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hb_full_m[i] = 1'b0;
      exp_last[i]  = 8'h00;
    end
  endtask

  logic [7:0] mo_buf     [8];
  logic [7:0] mi_buf     [8];
  logic [7:0] exp_tx     [9];
  bit         refill_en  [8];
  logic [7:0] refill_val [8];

  task automatic hwait();
    repeat (HALF) @(posedge i_clk);
    #1;
  endtask

  task automatic tx_write(input int m, input logic [7:0] b);
    chk("tx_ready_before_write", 32'(tx_ready[m]), 32'(!hb_full_m[m]));
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(posedge i_clk);
    #1;
    tx_dv[m]   = 1'b0;
    if (!hb_full_m[m]) begin
      hb_full_m[m] = 1'b1;
      hb_m[m]      = b;
    end
  endtask

  task automatic clr_refill();
    for (int i = 0; i < 8; i++) refill_en[i] = 1'b0;
  endtask

  // Master: nbits bits clocked out of mo_buf, MISO captured into mi_buf
  task automatic spi_xfer(input int m, input int nbits, input bit raise_cs);
    logic cpol, cpha;
    int   b, k;
    cpol = m[1];
    cpha = m[0];
    sck[m]  = cpol;
    cs_n[m] = 1'b0;
    exp_tx[0] = model_start(m);
    hwait();
    for (int i = 0; i < nbits; i++) begin
      b = i / 8;
      k = 7 - (i % 8);
      if (i % 8 == 3 && refill_en[b]) tx_write(m, refill_val[b]);
      if (!cpha) begin
        mosi[m] = mo_buf[b][k];
        hwait();
        sck[m] = ~cpol;
        mi_buf[b][k] = miso[m];
        hwait();
        sck[m] = cpol;
      end else begin
        sck[m]  = ~cpol;
        mosi[m] = mo_buf[b][k];
        hwait();
        sck[m] = cpol;
        mi_buf[b][k] = miso[m];
        hwait();
      end
      if (i % 8 == 7) exp_tx[b + 1] = model_start(m);
    end
    hwait();
    if (raise_cs) begin
      cs_n[m] = 1'b1;
      hwait();
      hwait();
    end
  endtask

  task automatic run_xfer(input int m, input int nbits);
    int base, full;
    base = rx_cnt[m];
    full = nbits / 8;
    spi_xfer(m, nbits, 1'b1);
    for (int n = 0; n < full; n++) begin
      chk($sformatf("m%0d_miso_byte%0d", m, n), 32'(mi_buf[n]), 32'(exp_tx[n]));
      chk($sformatf("m%0d_rx_byte%0d", m, n), 32'(rx_log[m][(base + n) % 64]), 32'(mo_buf[n]));
    end
    if (full > 0) exp_last[m] = mo_buf[full - 1];
    chk($sformatf("m%0d_rx_count", m), 32'(rx_cnt[m] - base), 32'(full));
    chk($sformatf("m%0d_rx_last", m), 32'(rx_byte[m]), 32'(exp_last[m]));
    chk($sformatf("m%0d_miso_idle", m), 32'(miso[m]), 32'(MISO_IDLE));
    chk($sformatf("m%0d_tx_ready", m), 32'(tx_ready[m]), 32'(!hb_full_m[m]));
  endtask

  task automatic chk_reset_state(input int m);
    chk($sformatf("rst_m%0d_rx_dv", m), 32'(rx_dv[m]), 32'd0);
    chk($sformatf("rst_m%0d_rx_byte", m), 32'(rx_byte[m]), 32'h00);
    chk($sformatf("rst_m%0d_tx_ready", m), 32'(tx_ready[m]), 32'd1);
    chk($sformatf("rst_m%0d_miso", m), 32'(miso[m]), 32'(MISO_IDLE));
  endtask

  initial begin
    int base, m, nbytes, nbits;
    for (int i = 0; i < 4; i++) begin
      sck[i] = i[1]; cs_n[i] = 1'b1; mosi[i] = 1'b0; tx_dv[i] = 1'b0; tx_byte[i] = 8'h00;
    end
    model_reset();
    clr_refill();
    repeat (4) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    for (int i = 0; i < 4; i++) chk_reset_state(i);

    // mode 0, preloaded byte
    tx_write(0, 8'h3C);
    mo_buf[0] = 8'hC1;
    run_xfer(0, 8);

    // mode 3, back-to-back under continuous CS with a refill
    tx_write(3, 8'hA5);
    refill_en[0] = 1'b1; refill_val[0] = 8'h5A;
    mo_buf[0] = 8'hBE; mo_buf[1] = 8'hEF;
    run_xfer(3, 16);
    clr_refill();

    // mode 1, empty buffer
    mo_buf[0] = 8'h12;
    run_xfer(1, 8);

    // mode 2, aborted byte between two good ones
    mo_buf[0] = 8'h44;
    run_xfer(2, 8);
    mo_buf[0] = 8'h77;
    run_xfer(2, 5);
    mo_buf[0] = 8'h81;
    run_xfer(2, 8);

    // second write while full is dropped
    tx_write(0, 8'h11);
    chk("tx_ready_after_write", 32'(tx_ready[0]), 32'd0);
    tx_write(0, 8'h22);
    mo_buf[0] = 8'h5E;
    run_xfer(0, 8);

    // reset mid-byte with CS_n held low
    tx_write(0, 8'h66);
    mo_buf[0] = 8'hF0;
    spi_xfer(0, 4, 1'b0);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    model_reset();
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 4; i++) chk_reset_state(i);
    base = rx_cnt[0];
    for (int i = 0; i < 16; i++) begin
      mosi[0] = 1'($urandom_range(0, 1));
      sck[0]  = ~sck[0];
      hwait();
    end
    chk("rst_no_rx_while_cs_low", 32'(rx_cnt[0] - base), 32'd0);
    chk("rst_rx_byte_held", 32'(rx_byte[0]), 32'h00);
    cs_n[0] = 1'b1;
    hwait();
    hwait();
    mo_buf[0] = 8'h9C;
    run_xfer(0, 8);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      m      = $urandom_range(0, 3);
      nbytes = $urandom_range(1, 3);
      nbits  = nbytes * 8;
      if ($urandom_range(0, 3) == 0) nbits = (nbytes - 1) * 8 + $urandom_range(1, 7);
      for (int n = 0; n < 8; n++) begin
        mo_buf[n]     = 8'($urandom);
        refill_en[n]  = ($urandom_range(0, 1) == 1);
        refill_val[n] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) tx_write(m, 8'($urandom));
      if ($urandom_range(0, 2) == 0) tx_write(m, 8'($urandom));
      run_xfer(m, nbits);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
